// File: rtl/pipeline_hazard_ctrl.sv
// Load-use hazard controller for a 5-stage pipeline.
// A per-register scoreboard counts down the cycles until a load's data can be
// forwarded into p3. A reader in p2 that hits a pending entry is held in place
// and a bubble is sent down into p3 until the entry clears. A taken branch in
// p3 squashes p1/p2. A busy data memory freezes the whole pipe, including this
// block's own state.
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_WIDTH = 4,
    parameter int LOAD_LAT       = 1,
    parameter int ZERO_REG       = 1,
    parameter int CNT_WIDTH      = 16
) (
    input  logic                      clk,
    input  logic                      RST,
    input  logic                      valid_p2,
    input  logic [REG_ADDR_WIDTH-1:0] A_addr,
    input  logic [REG_ADDR_WIDTH-1:0] B_addr,
    input  logic                      A_used,
    input  logic                      B_used,
    input  logic                      wr_en_p2,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr_p2,
    input  logic                      is_load_p2,
    input  logic                      branch_taken_p3,
    input  logic                      mem_busy,
    output logic                      stall_p12,
    output logic                      bubble_p3,
    output logic                      flush_p12,
    output logic                      freeze,
    output logic [CNT_WIDTH-1:0]      stall_cnt
);

    localparam int         NUM_REGS = 1 << REG_ADDR_WIDTH;
    localparam logic [1:0] LAT_VAL  = 2'(LOAD_LAT);
    localparam logic       ZERO_EN  = (ZERO_REG != 0);

    // Remaining bubble cycles owed by a reader of each register.
    logic [1:0]           pend_reg [NUM_REGS];
    logic [CNT_WIDTH-1:0] stall_cnt_reg;

    logic haz_a;
    logic haz_b;
    logic haz;
    logic freeze_int;
    logic flush_int;
    logic stall_int;
    logic bubble_int;
    logic issue;
    logic wr_track;

    // Hazard detection and stall/flush/freeze priority from the current state.
    always_comb begin
        haz_a      = A_used & (pend_reg[A_addr] != 2'd0)
                     & ~(ZERO_EN & (A_addr == '0));
        haz_b      = B_used & (pend_reg[B_addr] != 2'd0)
                     & ~(ZERO_EN & (B_addr == '0));
        haz        = valid_p2 & (haz_a | haz_b);
        freeze_int = mem_busy;
        flush_int  = branch_taken_p3 & ~mem_busy;
        stall_int  = freeze_int | (haz & ~flush_int);
        bubble_int = haz & ~flush_int & ~freeze_int;
        issue      = valid_p2 & ~stall_int & ~flush_int;
        // Only an instruction that actually leaves p2 may touch the scoreboard;
        // the hardwired-zero register is never tracked.
        wr_track   = issue & wr_en_p2 & ~(ZERO_EN & (wr_addr_p2 == '0));
    end

    // Outputs are forced low for as long as reset is held, independent of the clock.
    always_comb begin
        freeze    = freeze_int & ~RST;
        flush_p12 = flush_int  & ~RST;
        stall_p12 = stall_int  & ~RST;
        bubble_p3 = bubble_int & ~RST;
        stall_cnt = stall_cnt_reg;
    end

    // One down-counter per register: a new write overrides the decrement; a
    // load arms the entry, an ALU write clears any older pending load (WAW).
    generate
        for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_pend
            always_ff @(posedge clk or posedge RST) begin
                if (RST) begin
                    pend_reg[gi] <= 2'd0;
                end else if (!freeze_int) begin
                    if (wr_track && (wr_addr_p2 == REG_ADDR_WIDTH'(gi))) begin
                        pend_reg[gi] <= is_load_p2 ? LAT_VAL : 2'd0;
                    end else if (pend_reg[gi] != 2'd0) begin
                        pend_reg[gi] <= pend_reg[gi] - 2'd1;
                    end
                end
            end
        end
    endgenerate

    // Saturating count of load-use bubble cycles.
    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            stall_cnt_reg <= '0;
        end else if (bubble_int && (stall_cnt_reg != '1)) begin
            stall_cnt_reg <= stall_cnt_reg + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl. Three instances with different
// LOAD_LAT / ZERO_REG / CNT_WIDTH share one input stream; a cycle-count model
// (each register has the "active cycle" at which its data becomes forwardable)
// predicts every output of every instance, with directed constants on top.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       RST;
    logic       valid_p2, A_used, B_used, wr_en_p2, is_load_p2;
    logic       branch_taken_p3, mem_busy;
    logic [3:0] A_addr, B_addr, wr_addr_p2;

    logic       stall_o [3];
    logic       bubble_o[3];
    logic       flush_o [3];
    logic       freeze_o[3];
    logic [3:0]  cnt0;
    logic [15:0] cnt1;
    logic [7:0]  cnt2;

    // Model parameters per instance.
    int  lat [3] = '{1, 2, 3};
    bit  zr  [3] = '{0, 1, 1};
    int  cmax[3] = '{15, 65535, 255};

    // Model state: avail[k][r] is the active-cycle index from which r is free.
    int  avail[3][16];
    int  tick [3];
    int  cnt  [3];

    int  checks = 0;
    int  passes = 0;
    int  fails  = 0;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(4), .LOAD_LAT(1), .ZERO_REG(0), .CNT_WIDTH(4)) dut0 (
        .clk(clk), .RST(RST), .valid_p2(valid_p2), .A_addr(A_addr), .B_addr(B_addr),
        .A_used(A_used), .B_used(B_used), .wr_en_p2(wr_en_p2), .wr_addr_p2(wr_addr_p2),
        .is_load_p2(is_load_p2), .branch_taken_p3(branch_taken_p3), .mem_busy(mem_busy),
        .stall_p12(stall_o[0]), .bubble_p3(bubble_o[0]), .flush_p12(flush_o[0]),
        .freeze(freeze_o[0]), .stall_cnt(cnt0));

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(4), .LOAD_LAT(2), .ZERO_REG(1), .CNT_WIDTH(16)) dut1 (
        .clk(clk), .RST(RST), .valid_p2(valid_p2), .A_addr(A_addr), .B_addr(B_addr),
        .A_used(A_used), .B_used(B_used), .wr_en_p2(wr_en_p2), .wr_addr_p2(wr_addr_p2),
        .is_load_p2(is_load_p2), .branch_taken_p3(branch_taken_p3), .mem_busy(mem_busy),
        .stall_p12(stall_o[1]), .bubble_p3(bubble_o[1]), .flush_p12(flush_o[1]),
        .freeze(freeze_o[1]), .stall_cnt(cnt1));

    pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(4), .LOAD_LAT(3), .ZERO_REG(1), .CNT_WIDTH(8)) dut2 (
        .clk(clk), .RST(RST), .valid_p2(valid_p2), .A_addr(A_addr), .B_addr(B_addr),
        .A_used(A_used), .B_used(B_used), .wr_en_p2(wr_en_p2), .wr_addr_p2(wr_addr_p2),
        .is_load_p2(is_load_p2), .branch_taken_p3(branch_taken_p3), .mem_busy(mem_busy),
        .stall_p12(stall_o[2]), .bubble_p3(bubble_o[2]), .flush_p12(flush_o[2]),
        .freeze(freeze_o[2]), .stall_cnt(cnt2));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s dut%0d t=%0t observed=%0h expected=%0h", tag, k, $time, obs, exp);
        end
    endtask

    function automatic logic [31:0] cnt_of(input int k);
        case (k)
            0:       return 32'(cnt0);
            1:       return 32'(cnt1);
            default: return 32'(cnt2);
        endcase
    endfunction

    function automatic bit reg_busy(input int k, input logic [3:0] r);
        if (zr[k] && r == 4'd0) return 1'b0;
        return avail[k][r] > tick[k];
    endfunction

    // Expected outputs for instance k from the model state and current inputs.
    task automatic model_out(input int k, output bit st, output bit bu, output bit fl,
                             output bit fr, output bit iss);
        bit h;
        h   = valid_p2 && ((A_used && reg_busy(k, A_addr)) || (B_used && reg_busy(k, B_addr)));
        fr  = mem_busy;
        fl  = branch_taken_p3 && !mem_busy;
        st  = fr || (h && !fl);
        bu  = h && !fl && !fr;
        iss = valid_p2 && !st && !fl;
        if (RST) begin
            st = 0; bu = 0; fl = 0; fr = 0; iss = 0;
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            tick[k] = 0;
            cnt[k]  = 0;
            for (int r = 0; r < 16; r++) avail[k][r] = 0;
        end
    endtask

    // Advance the model across one rising edge, using the pre-edge inputs.
    task automatic model_update();
        bit st, bu, fl, fr, iss;
        if (RST) begin
            model_reset();
            return;
        end
        for (int k = 0; k < 3; k++) begin
            model_out(k, st, bu, fl, fr, iss);
            if (!mem_busy) begin
                if (iss && wr_en_p2 && !(zr[k] && wr_addr_p2 == 4'd0))
                    avail[k][wr_addr_p2] = is_load_p2 ? tick[k] + 1 + lat[k] : 0;
                if (bu && cnt[k] < cmax[k]) cnt[k]++;
                tick[k]++;
            end
        end
    endtask

    task automatic check_all();
        bit st, bu, fl, fr, iss;
        for (int k = 0; k < 3; k++) begin
            model_out(k, st, bu, fl, fr, iss);
            chk("stall_p12", k, 32'(stall_o[k]),  32'(st));
            chk("bubble_p3", k, 32'(bubble_o[k]), 32'(bu));
            chk("flush_p12", k, 32'(flush_o[k]),  32'(fl));
            chk("freeze",    k, 32'(freeze_o[k]), 32'(fr));
            chk("stall_cnt", k, cnt_of(k),        32'(cnt[k]));
        end
    endtask

    task automatic settle();
        #1;
        check_all();
    endtask

    task automatic advance();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic idle();
        valid_p2 = 0; A_used = 0; B_used = 0; wr_en_p2 = 0; is_load_p2 = 0;
        A_addr = 0; B_addr = 0; wr_addr_p2 = 0; branch_taken_p3 = 0; mem_busy = 0;
    endtask

    task automatic drive_load(input logic [3:0] dst);
        idle();
        valid_p2 = 1; wr_en_p2 = 1; is_load_p2 = 1; wr_addr_p2 = dst;
    endtask

    task automatic drive_reader(input logic [3:0] src);
        idle();
        valid_p2 = 1; A_used = 1; A_addr = src;
    endtask

    task automatic do_reset();
        RST = 1;
        idle();
        #1;
        model_reset();
        advance();
        RST = 0;
    endtask

    initial begin
        RST = 1;
        idle();
        model_reset();
        @(negedge clk);
        settle();
        chk("reset_cnt", 1, 32'(cnt1), 32'd0);
        advance();
        RST = 0;

        // Load r3 then a reader held in p2: bubbles = LOAD_LAT per instance.
        drive_load(4'd3);   settle(); advance();
        drive_reader(4'd3); settle();
        chk("ll_t1_bubble", 0, 32'(bubble_o[0]), 32'd1);
        advance();
        settle();
        chk("ll_t2_bubble", 0, 32'(bubble_o[0]), 32'd0);
        chk("ll_t2_bubble", 1, 32'(bubble_o[1]), 32'd1);
        advance();
        settle(); advance();
        idle(); settle();
        chk("ll_cnt", 0, 32'(cnt0), 32'd1);
        chk("ll_cnt", 1, 32'(cnt1), 32'd2);
        chk("ll_cnt", 2, 32'(cnt2), 32'd3);
        advance();

        // Freeze in the middle of a LOAD_LAT=2 stall.
        do_reset();
        drive_load(4'd3);   settle(); advance();
        drive_reader(4'd3); settle(); advance();
        mem_busy = 1;       settle();
        chk("frz_freeze", 1, 32'(freeze_o[1]), 32'd1);
        chk("frz_bubble", 1, 32'(bubble_o[1]), 32'd0);
        advance();
        mem_busy = 0;       settle();
        chk("frz_resume_bubble", 1, 32'(bubble_o[1]), 32'd1);
        advance();
        settle();
        chk("frz_issue_stall", 1, 32'(stall_o[1]), 32'd0);
        chk("frz_cnt", 1, 32'(cnt1), 32'd2);
        advance();

        // WAW: ALU write clears the older pending load.
        do_reset();
        drive_load(4'd5); settle(); advance();
        idle(); valid_p2 = 1; wr_en_p2 = 1; wr_addr_p2 = 4'd5; settle(); advance();
        drive_reader(4'd5); settle();
        for (int k = 0; k < 3; k++) chk("waw_stall", k, 32'(stall_o[k]), 32'd0);
        advance();

        // Load r0: tracked only where ZERO_REG=0.
        do_reset();
        drive_load(4'd0);   settle(); advance();
        drive_reader(4'd0); settle();
        chk("r0_bubble", 0, 32'(bubble_o[0]), 32'd1);
        chk("r0_bubble", 1, 32'(bubble_o[1]), 32'd0);
        advance();

        // Hazard together with a taken branch: flush wins, scoreboard still ages.
        do_reset();
        drive_load(4'd4);   settle(); advance();
        drive_reader(4'd4); branch_taken_p3 = 1; settle();
        chk("br_flush", 1, 32'(flush_o[1]),  32'd1);
        chk("br_stall", 1, 32'(stall_o[1]),  32'd0);
        chk("br_bubble", 1, 32'(bubble_o[1]), 32'd0);
        advance();
        drive_reader(4'd4); settle();
        chk("br_after_bubble", 0, 32'(bubble_o[0]), 32'd0);
        chk("br_after_bubble", 1, 32'(bubble_o[1]), 32'd1);
        advance();

        // Asynchronous reset in the middle of a stall.
        do_reset();
        drive_load(4'd7);   settle(); advance();
        drive_reader(4'd7); mem_busy = 1; settle();
        RST = 1; #1;
        model_reset();
        for (int k = 0; k < 3; k++) begin
            chk("rst_stall",  k, 32'(stall_o[k]),  32'd0);
            chk("rst_freeze", k, 32'(freeze_o[k]), 32'd0);
        end
        @(posedge clk); @(negedge clk);
        RST = 0; mem_busy = 0; settle();
        chk("rst_release_stall", 1, 32'(stall_o[1]), 32'd0);
        chk("rst_release_cnt",   1, 32'(cnt1),       32'd0);
        advance();

        // Randomized traffic against the model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            idle();
            valid_p2        = ($urandom_range(0, 9) < 8);
            A_used          = $urandom_range(0, 1);
            B_used          = $urandom_range(0, 1);
            A_addr          = 4'($urandom_range(0, 5));
            B_addr          = 4'($urandom_range(0, 5));
            wr_en_p2        = ($urandom_range(0, 9) < 7);
            wr_addr_p2      = 4'($urandom_range(0, 5));
            is_load_p2      = ($urandom_range(0, 9) < 5);
            branch_taken_p3 = ($urandom_range(0, 9) == 0);
            mem_busy        = ($urandom_range(0, 99) < 15);
            settle();
            advance();
        end

        // Drive the 4-bit counter of dut0 past saturation.
        for (int i = 0; i < 20; i++) begin
            drive_load(4'd2);   settle(); advance();
            drive_reader(4'd2); settle(); advance();
        end
        idle(); settle();
        chk("sat_cnt", 0, 32'(cnt0), 32'hF);
        advance();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
